// File: rtl/nabp_multi_mapper.sv
// Multi-channel projection mapper: CHANNELS lockstep fixed-point accumulators mapped to
// rounded, range-checked line indices. Optional feature macro: NABP_MAPPER_CLAMP_EN.
module nabp_multi_mapper #(
  parameter int CHANNELS  = 4,
  parameter int LINE_SIZE = 256,
  parameter int S_WIDTH   = 9,
  parameter int ACC_INT   = 10,
  parameter int ACC_FRAC  = 8,
  parameter int CNT_WIDTH = 9
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [CHANNELS*(ACC_INT+ACC_FRAC)-1:0]  mp_accu_init,
  input  logic [CHANNELS*(ACC_INT+ACC_FRAC)-1:0]  mp_accu_base,
  input  logic                                    sh_kick,
  input  logic                                    sh_shift_en,
  input  logic                                    sh_done,
  output logic [CHANNELS*S_WIDTH-1:0]             fr_s_val,
  output logic [CHANNELS-1:0]                     fr_in_range,
  output logic                                    fr_valid,
  output logic                                    mp_busy,
  output logic                                    mp_done,
  output logic [CNT_WIDTH-1:0]                    mp_shift_count,
  output logic                                    mp_overrun
);

  localparam int ACC_W = ACC_INT + ACC_FRAC;
  localparam logic [ACC_W:0]   HALF = (ACC_W+1)'(1) << (ACC_FRAC - 1);
  localparam logic [63:0]      MAXV = 64'(LINE_SIZE) << ACC_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MAPPING = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                          rst_sync_q;
  logic [ACC_W-1:0]              accu_q [CHANNELS];
  logic [CHANNELS*S_WIDTH-1:0]   s_q, s_d;
  logic [CHANNELS-1:0]           rng_q, rng_d;
  logic                          valid_q;
  logic [CNT_WIDTH-1:0]          cnt_q;
  logic                          ov_q;
  logic                          start, shift;
  logic [ACC_W:0]                r;

  // Assertion is asynchronous; release is retimed so the first active edge is one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 1'b0;
    else          rst_sync_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    shift   = 1'b0;
    mp_busy = 1'b0;
    mp_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        start = sh_kick;
        if (sh_kick) state_d = ST_MAPPING;
      end
      ST_MAPPING: begin
        mp_busy = 1'b1;
        shift   = sh_shift_en;
        if (sh_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        mp_busy = 1'b1;
        mp_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Rounding add is one bit wider than the accumulator so the sign survives overflow.
  always_comb begin
    s_d   = '0;
    rng_d = '0;
    r     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      r = {accu_q[c][ACC_W-1], accu_q[c]} + HALF;
      if (r[ACC_W]) begin
        s_d[c*S_WIDTH +: S_WIDTH] = '0;
      end else if (64'(r[ACC_W-1:0]) >= MAXV) begin
`ifdef NABP_MAPPER_CLAMP_EN
        s_d[c*S_WIDTH +: S_WIDTH] = S_WIDTH'(LINE_SIZE - 1);
`else
        s_d[c*S_WIDTH +: S_WIDTH] = '0;
`endif
      end else begin
        s_d[c*S_WIDTH +: S_WIDTH] = r[ACC_FRAC +: S_WIDTH];
        rng_d[c]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      for (int unsigned c = 0; c < CHANNELS; c++) accu_q[c] <= '0;
      s_q     <= '0;
      rng_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      valid_q <= shift;
      if (start) begin
        for (int unsigned c = 0; c < CHANNELS; c++)
          accu_q[c] <= mp_accu_init[c*ACC_W +: ACC_W];
        cnt_q <= '0;
        ov_q  <= 1'b0;
      end else if (shift) begin
        for (int unsigned c = 0; c < CHANNELS; c++)
          accu_q[c] <= accu_q[c] + mp_accu_base[c*ACC_W +: ACC_W];
        s_q   <= s_d;
        rng_q <= rng_d;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(LINE_SIZE)) ov_q <= 1'b1;
      end
    end
  end

  assign fr_s_val       = s_q;
  assign fr_in_range    = rng_q;
  assign fr_valid       = valid_q;
  assign mp_shift_count = cnt_q;
  assign mp_overrun     = ov_q;

endmodule

// File: tb/tb_nabp_multi_mapper.sv
// Self-checking bench for nabp_multi_mapper against an integer-arithmetic reference model.
module tb_nabp_multi_mapper;
  localparam int CH = 4;
  localparam int AW = 18;
  localparam int SW = 9;
  localparam int LS = 256;
  localparam int CW = 9;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [CH*AW-1:0]   mp_accu_init = '0;
  logic [CH*AW-1:0]   mp_accu_base = '0;
  logic               sh_kick = 1'b0, sh_shift_en = 1'b0, sh_done = 1'b0;
  logic [CH*SW-1:0]   fr_s_val;
  logic [CH-1:0]      fr_in_range;
  logic               fr_valid, mp_busy, mp_done, mp_overrun;
  logic [CW-1:0]      mp_shift_count;

  int n_checks = 0;
  int n_fail   = 0;

  int m_init [CH];
  int m_base [CH];
  int m_acc  [CH];
  int m_cnt  = 0;
  bit m_ov   = 0;
  int e_s    [CH];
  bit e_r    [CH];

  nabp_multi_mapper #(
    .CHANNELS(CH), .LINE_SIZE(LS), .S_WIDTH(SW), .ACC_INT(10), .ACC_FRAC(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mp_accu_init(mp_accu_init), .mp_accu_base(mp_accu_base),
    .sh_kick(sh_kick), .sh_shift_en(sh_shift_en), .sh_done(sh_done),
    .fr_s_val(fr_s_val), .fr_in_range(fr_in_range), .fr_valid(fr_valid),
    .mp_busy(mp_busy), .mp_done(mp_done), .mp_shift_count(mp_shift_count),
    .mp_overrun(mp_overrun)
  );

  always #5 clk = ~clk;

  function automatic int wrap18(int v);
    int w = v & 32'h3FFFF;
    if (w >= 32'h20000) w -= 32'h40000;
    return w;
  endfunction

  function automatic int map_s(int a);
    int r = a + 128;
    if (r < 0) return 0;
`ifdef NABP_MAPPER_CLAMP_EN
    if (r >= LS * 256) return LS - 1;
`else
    if (r >= LS * 256) return 0;
`endif
    return r / 256;
  endfunction

  function automatic bit map_r(int a);
    int r = a + 128;
    return (r >= 0) && (r < LS * 256);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lane(input int c, input int init, input int base);
    m_init[c] = wrap18(init);
    m_base[c] = wrap18(base);
    mp_accu_init[c*AW +: AW] = AW'(init);
    mp_accu_base[c*AW +: AW] = AW'(base);
  endtask

  task automatic do_kick();
    sh_kick = 1'b1;
    tick();
    sh_kick = 1'b0;
    for (int c = 0; c < CH; c++) m_acc[c] = m_init[c];
    m_cnt = 0;
    m_ov  = 0;
  endtask

  task automatic do_shift(input bit with_done);
    for (int c = 0; c < CH; c++) begin
      e_s[c]   = map_s(m_acc[c]);
      e_r[c]   = map_r(m_acc[c]);
      m_acc[c] = wrap18(m_acc[c] + m_base[c]);
    end
    if (m_cnt == LS) m_ov = 1;
    if (m_cnt < 511) m_cnt++;
    sh_shift_en = 1'b1;
    sh_done     = with_done;
    tick();
    sh_shift_en = 1'b0;
    sh_done     = 1'b0;
  endtask

  task automatic do_done();
    sh_done = 1'b1;
    tick();
    sh_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (fr_s_val !== '0 || fr_in_range !== '0 || fr_valid !== 1'b0 || mp_busy !== 1'b0 ||
        mp_done !== 1'b0 || mp_shift_count !== '0 || mp_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: s=%h rng=%b v=%b busy=%b done=%b cnt=%0d ov=%b, want all 0",
               fr_s_val, fr_in_range, fr_valid, mp_busy, mp_done, mp_shift_count, mp_overrun);
    end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (mp_busy !== 1'b0 || fr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: busy=%b v=%b, want 0 0", mp_busy, fr_valid);
    end
  endtask

  task automatic test_single();
    int want [4] = '{10, 12, 13, 15};
    set_lane(0, 32'h0A40, 32'h0180);
    for (int c = 1; c < CH; c++) set_lane(c, 0, 0);
    do_kick();
    n_checks++;
    if (mp_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: got %b want 1", mp_busy);
    end
    for (int i = 0; i < 4; i++) begin
      do_shift(0);
      n_checks++;
      if (fr_valid !== 1'b1 || fr_s_val[0 +: SW] !== SW'(want[i]) || fr_in_range[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_shift%0d: v=%b s=%0d rng=%b, want v=1 s=%0d rng=1",
                 i, fr_valid, fr_s_val[0 +: SW], fr_in_range[0], want[i]);
      end
    end
    n_checks++;
    if (mp_shift_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL single_count: got %0d want 4", mp_shift_count);
    end
    sh_done = 1'b1;
    tick();
    sh_done = 1'b0;
    n_checks++;
    if (mp_done !== 1'b1 || mp_busy !== 1'b1 || fr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: done=%b busy=%b v=%b, want 1 1 0", mp_done, mp_busy, fr_valid);
    end
    tick();
    n_checks++;
    if (mp_done !== 1'b0 || mp_busy !== 1'b0 || fr_s_val[0 +: SW] !== SW'(15)) begin
      n_fail++;
      $display("FAIL drain_exit: done=%b busy=%b s=%0d, want 0 0 15 (held)",
               mp_done, mp_busy, fr_s_val[0 +: SW]);
    end
  endtask

  task automatic test_edges();
    int up_s;
`ifdef NABP_MAPPER_CLAMP_EN
    up_s = 255;
`else
    up_s = 0;
`endif
    set_lane(0, -192, 256);
    set_lane(1, 65344, 128);
    do_kick();
    do_shift(0);
    n_checks++;
    if (fr_s_val[0 +: SW] !== SW'(0) || fr_in_range[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL lower_first: s=%0d rng=%b, want 0 0", fr_s_val[0 +: SW], fr_in_range[0]);
    end
    n_checks++;
    if (fr_s_val[SW +: SW] !== SW'(255) || fr_in_range[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL upper_first: s=%0d rng=%b, want 255 1", fr_s_val[SW +: SW], fr_in_range[1]);
    end
    do_shift(0);
    n_checks++;
    if (fr_s_val[0 +: SW] !== SW'(0) || fr_in_range[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL lower_second: s=%0d rng=%b, want 0 1", fr_s_val[0 +: SW], fr_in_range[0]);
    end
    n_checks++;
    if (fr_s_val[SW +: SW] !== SW'(up_s) || fr_in_range[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL upper_second: s=%0d rng=%b, want %0d 0", fr_s_val[SW +: SW], fr_in_range[1], up_s);
    end
    do_done();
  endtask

  task automatic test_four();
    int inits [CH] = '{0, 64*256, 128*256, 200*256};
    int bases [CH] = '{256, -256, 128, 512};
    for (int c = 0; c < CH; c++) set_lane(c, inits[c], bases[c]);
    do_kick();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        tick();
        n_checks++;
        if (fr_valid !== 1'b0 || fr_s_val[3*SW +: SW] !== SW'(e_s[3])) begin
          n_fail++;
          $display("FAIL four_hold: v=%b s3=%0d, want 0 %0d", fr_valid, fr_s_val[3*SW +: SW], e_s[3]);
        end
      end
      do_shift(0);
      for (int c = 0; c < CH; c++) begin
        n_checks++;
        if (fr_s_val[c*SW +: SW] !== SW'(e_s[c]) || fr_in_range[c] !== e_r[c]) begin
          n_fail++;
          $display("FAIL four_lane%0d_shift%0d: s=%0d rng=%b, want %0d %b",
                   c, i, fr_s_val[c*SW +: SW], fr_in_range[c], e_s[c], e_r[c]);
        end
      end
    end
    do_done();
  endtask

  task automatic test_random();
    for (int c = 0; c < CH; c++) begin
      if (c < 2) set_lane(c, int'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)) - 512);
      else       set_lane(c, int'($urandom_range(0, 32'h3FFFF)), int'($urandom_range(0, 32'h3FFFF)));
    end
    do_kick();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        do_shift(0);
        n_checks++;
        if (fr_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_valid%0d: got %b want 1", i, fr_valid);
        end
      end else begin
        tick();
        n_checks++;
        if (fr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_idle%0d: got %b want 0", i, fr_valid);
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (m_cnt > 0) begin
          n_checks++;
          if (fr_s_val[c*SW +: SW] !== SW'(e_s[c]) || fr_in_range[c] !== e_r[c]) begin
            n_fail++;
            $display("FAIL rand_lane%0d_cyc%0d: s=%0d rng=%b, want %0d %b",
                     c, i, fr_s_val[c*SW +: SW], fr_in_range[c], e_s[c], e_r[c]);
          end
        end
      end
    end
    n_checks++;
    if (mp_shift_count !== CW'(m_cnt)) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", mp_shift_count, m_cnt);
    end
    do_done();
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < CH; c++) set_lane(c, (c + 1) * 1000, 300 - c * 100);
    do_kick();
    do_shift(0);
    do_shift(0);
    mp_accu_init = '1;
    sh_kick = 1'b1;
    tick();
    sh_kick = 1'b0;
    n_checks++;
    if (mp_shift_count !== CW'(2) || mp_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL kick_in_mapping: cnt=%0d busy=%b, want 2 1", mp_shift_count, mp_busy);
    end
    do_shift(0);
    do_shift(1);
    for (int c = 0; c < CH; c++) begin
      n_checks++;
      if (fr_valid !== 1'b1 || fr_s_val[c*SW +: SW] !== SW'(e_s[c]) || fr_in_range[c] !== e_r[c]) begin
        n_fail++;
        $display("FAIL simul_lane%0d: v=%b s=%0d rng=%b, want 1 %0d %b",
                 c, fr_valid, fr_s_val[c*SW +: SW], fr_in_range[c], e_s[c], e_r[c]);
      end
    end
    n_checks++;
    if (mp_done !== 1'b1 || mp_busy !== 1'b1 || mp_shift_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL simul_drain: done=%b busy=%b cnt=%0d, want 1 1 4", mp_done, mp_busy, mp_shift_count);
    end
    sh_kick = 1'b1;
    tick();
    sh_kick = 1'b0;
    n_checks++;
    if (mp_done !== 1'b0 || mp_busy !== 1'b0 || mp_shift_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL kick_in_drain: done=%b busy=%b cnt=%0d, want 0 0 4", mp_done, mp_busy, mp_shift_count);
    end
    tick();
    n_checks++;
    if (mp_done !== 1'b0 || mp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_once: done=%b busy=%b, want 0 0", mp_done, mp_busy);
    end
  endtask

  task automatic test_midreset();
    for (int c = 0; c < CH; c++) set_lane(c, c * 5000 + 700, 256 + c * 64);
    do_kick();
    repeat (3) do_shift(0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (fr_s_val !== '0 || fr_in_range !== '0 || fr_valid !== 1'b0 || mp_busy !== 1'b0 ||
        mp_done !== 1'b0 || mp_shift_count !== '0 || mp_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: s=%h rng=%b v=%b busy=%b done=%b cnt=%0d ov=%b, want all 0",
               fr_s_val, fr_in_range, fr_valid, mp_busy, mp_done, mp_shift_count, mp_overrun);
    end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    do_kick();
    do_shift(0);
    for (int c = 0; c < CH; c++) begin
      n_checks++;
      if (fr_s_val[c*SW +: SW] !== SW'(e_s[c]) || fr_in_range[c] !== e_r[c]) begin
        n_fail++;
        $display("FAIL restart_lane%0d: s=%0d rng=%b, want %0d %b",
                 c, fr_s_val[c*SW +: SW], fr_in_range[c], e_s[c], e_r[c]);
      end
    end
    do_done();
  endtask

  task automatic test_overrun();
    for (int c = 0; c < CH; c++) set_lane(c, 0, 0);
    do_kick();
    repeat (256) do_shift(0);
    n_checks++;
    if (mp_overrun !== 1'b0 || mp_shift_count !== CW'(256)) begin
      n_fail++;
      $display("FAIL overrun_256: ov=%b cnt=%0d, want 0 256", mp_overrun, mp_shift_count);
    end
    do_shift(0);
    n_checks++;
    if (mp_overrun !== 1'b1 || mp_shift_count !== CW'(257) || fr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_257: ov=%b cnt=%0d v=%b, want 1 257 1", mp_overrun, mp_shift_count, fr_valid);
    end
    do_done();
    n_checks++;
    if (mp_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b want 1", mp_overrun);
    end
    do_kick();
    n_checks++;
    if (mp_overrun !== 1'b0 || mp_shift_count !== '0) begin
      n_fail++;
      $display("FAIL overrun_clear: ov=%b cnt=%0d, want 0 0", mp_overrun, mp_shift_count);
    end
    do_done();
  endtask

  initial begin
    test_reset();
    test_single();
    test_edges();
    test_four();
    test_random();
    test_simultaneous();
    test_midreset();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
